// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared definitions for the multi-port register file. Holds
//               the clear-FSM state encoding, the default geometry and the
//               address of the hardwired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_xlen_default  = 32;
    localparam int c_nregs_default = 32;
    localparam int c_nrd_default   = 2;

    // Address of the hardwired-zero register (x0).
    localparam int REG_ZERO = 0;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy vector for long-latency producers, with
//               NRD combinational busy lookups.
// Ports       : clk, rst (async, active-high: clears every busy bit)
//               i_set_en/i_set_addr : mark a register pending
//               i_clr_en/i_clr_addr : writeback completes a register
//               i_raddr             : packed lookup addresses (NRD x AW)
//               o_busy              : raw busy bit per lookup port
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_en,
    input  logic [AW-1:0]     i_set_addr,
    input  logic              i_clr_en,
    input  logic [AW-1:0]     i_clr_addr,
    input  logic [NRD*AW-1:0] i_raddr,
    output logic [NRD-1:0]    o_busy
);

    logic [NREGS-1:0] r_busy;

    // The set is applied after the clear so a same-cycle write and reserve
    // to one register leaves it busy: the reserve belongs to a new producer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (i_clr_en) r_busy[i_clr_addr] <= 1'b0;
            if (i_set_en) r_busy[i_set_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_lookup
        assign o_busy[i] = r_busy[i_raddr[i*AW +: AW]];
    end

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-read-port integer register file with a
//               busy scoreboard and a post-reset clear sequencer, so the
//               array itself needs no reset. x0 is hardwired to zero.
// Ports       : clk, reset (async, active-high)
//               ready                 : array cleared, accepting operations
//               regwrite/waddr/wdata  : write port (also clears busy)
//               rsv_en/rsv_addr       : reserve (sets busy)
//               raddr/rdata/rbusy     : NRD packed read ports
// Config      : REGFILE_BYPASS_EN - when defined, a same-cycle write is
//               forwarded combinationally to matching read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = c_xlen_default,
    parameter int NREGS = c_nregs_default,
    parameter int NRD   = c_nrd_default
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               ready,
    input  logic                               regwrite,
    input  logic [$clog2(NREGS)-1:0]           waddr,
    input  logic [XLEN-1:0]                    wdata,
    input  logic                               rsv_en,
    input  logic [$clog2(NREGS)-1:0]           rsv_addr,
    input  logic [NRD*$clog2(NREGS)-1:0]       raddr,
    output logic [NRD*XLEN-1:0]                rdata,
    output logic [NRD-1:0]                     rbusy
);

    localparam int            AW     = $clog2(NREGS);
    localparam logic [AW-1:0] c_zero = AW'(REG_ZERO);
    localparam logic [AW-1:0] c_last = AW'(NREGS - 1);

    rf_state_t     r_state, w_state_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;

    logic [XLEN-1:0] r_mem [NREGS];

    logic           w_we;
    logic           w_rsv;
    logic [NRD-1:0] w_sb_busy;

    assign ready = (r_state == RF_RUN);
    assign w_we  = ready && regwrite && (waddr != c_zero);
    assign w_rsv = ready && rsv_en && (rsv_addr != c_zero);

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RF_CLEAR;
            r_idx   <= AW'(1);
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            RF_CLEAR: begin
                w_idx_nxt = r_idx + 1'b1;
                if (r_idx == c_last) w_state_nxt = RF_RUN;
            end
            RF_RUN:   w_state_nxt = RF_RUN;
            default:  w_state_nxt = RF_CLEAR;
        endcase
    end

    // ---------------- storage (reset-less) ----------------
    // Entry 0 is never written; reads of x0 are forced to zero instead.
    always_ff @(posedge clk) begin
        if (r_state == RF_CLEAR) begin
            r_mem[r_idx] <= '0;
        end else if (w_we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // ---------------- busy scoreboard ----------------
    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (reset),
        .i_set_en   (w_rsv),
        .i_set_addr (rsv_addr),
        .i_clr_en   (w_we),
        .i_clr_addr (waddr),
        .i_raddr    (raddr),
        .o_busy     (w_sb_busy)
    );

    // ---------------- read ports ----------------
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_gate;

        assign w_ra   = raddr[i*AW +: AW];
        // Outputs are held at zero during clear and for x0.
        assign w_gate = ready && (w_ra != c_zero);

`ifdef REGFILE_BYPASS_EN
        logic w_byp;
        logic w_rsv_same;

        assign w_byp      = w_we && (waddr == w_ra);
        assign w_rsv_same = w_rsv && (rsv_addr == w_ra);

        assign rdata[i*XLEN +: XLEN] = !w_gate ? '0 :
                                       (w_byp ? wdata : r_mem[w_ra]);
        // A forwarded write retires the producer, unless a new producer
        // reserves the same register this cycle (reserve is never bypassed).
        assign rbusy[i] = w_gate && ((w_byp && !w_rsv_same) ? 1'b0 : w_sb_busy[i]);
`else
        assign rdata[i*XLEN +: XLEN] = w_gate ? r_mem[w_ra] : '0;
        assign rbusy[i]              = w_gate && w_sb_busy[i];
`endif
    end

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp (XLEN=32, NREGS=32,
//               NRD=2). Directed scenarios followed by randomized traffic,
//               all checked against a behavioural array/busy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                ready;
    logic                regwrite = 1'b0;
    logic [AW-1:0]       waddr = '0;
    logic [XLEN-1:0]     wdata = '0;
    logic                rsv_en = 1'b0;
    logic [AW-1:0]       rsv_addr = '0;
    logic [NRD*AW-1:0]   raddr = '0;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain arrays plus a count of clear cycles remaining.
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_busy [NREGS];
    int              m_clr_left = NREGS - 1;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .regwrite (regwrite),
        .waddr    (waddr),
        .wdata    (wdata),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return !reset && (m_clr_left == 0);
    endfunction

    function automatic logic [XLEN-1:0] m_rdata(input int a);
        if (!m_ready() || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (regwrite && int'(waddr) == a) return wdata;
`endif
        return m_mem[a];
    endfunction

    function automatic logic m_rbusy(input int a);
        if (!m_ready() || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (regwrite && int'(waddr) == a && !(rsv_en && int'(rsv_addr) == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    // One clock: check every output at the falling edge, then advance the
    // model at the rising edge, and return 1 time unit after it.
    task automatic cycle();
        @(negedge clk);
        chk_eq("ready", {63'd0, ready}, {63'd0, m_ready()});
        for (int p = 0; p < NRD; p++) begin
            int a;
            a = int'(raddr[p*AW +: AW]);
            chk_eq($sformatf("rdata%0d[x%0d]", p, a), {32'd0, rdata[p*XLEN +: XLEN]}, {32'd0, m_rdata(a)});
            chk_eq($sformatf("rbusy%0d[x%0d]", p, a), {63'd0, rbusy[p]}, {63'd0, m_rbusy(a)});
        end
        @(posedge clk);
        if (reset) begin
            m_clr_left = NREGS - 1;
            for (int r = 0; r < NREGS; r++) begin
                m_mem[r]  = '0;
                m_busy[r] = 1'b0;
            end
        end else if (m_clr_left > 0) begin
            m_clr_left--;
        end else begin
            if (regwrite && waddr != 0) begin
                m_mem[waddr]  = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        regwrite = 1'b0;
        rsv_en   = 1'b0;
    endtask

    task automatic set_raddr(input int a0, input int a1);
        raddr = {AW'(a1), AW'(a0)};
    endtask

    // Counts rising edges after reset release until ready, bounded.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            cycle();
            n++;
        end
        chk_eq(tag, 64'(n), 64'(NREGS - 1));
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end

        // Reset clear: 2-cycle pulse, then exactly NREGS-1 edges to ready.
        reset = 1'b1;
        #1;
        chk_eq("reset_ready", {63'd0, ready}, 64'd0);
        chk_eq("reset_rbusy", {62'd0, rbusy}, 64'd0);
        chk_eq("reset_rdata", rdata, 64'd0);
        cycle();
        cycle();
        reset = 1'b0;
        wait_ready("clr_len");
        for (int r = 0; r < NREGS; r++) begin
            set_raddr(r, NREGS - 1 - r);
            cycle();
        end

        // Basic write/read with port 0 = x2, port 1 = x1.
        set_raddr(2, 1);
        regwrite = 1'b1; waddr = 5'd1; wdata = 32'hAAAA_AAAA;
        cycle();
        waddr = 5'd2; wdata = 32'h5555_5555;
        cycle();
        idle();
        chk_eq("basic_x2", {32'd0, rdata[31:0]},  64'h5555_5555);
        chk_eq("basic_x1", {32'd0, rdata[63:32]}, 64'hAAAA_AAAA);
        cycle();

        // x0 protection.
        set_raddr(0, 0);
        regwrite = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        cycle();
        idle();
        cycle();
        chk_eq("x0_data",  rdata, 64'd0);
        chk_eq("x0_rbusy", {62'd0, rbusy}, 64'd0);

        // Scoreboard on x5, both ports reading it.
        set_raddr(5, 5);
        rsv_en = 1'b1; rsv_addr = 5'd5;
        cycle();
        idle();
        chk_eq("sb_set", {62'd0, rbusy}, 64'd3);
        regwrite = 1'b1; waddr = 5'd5; wdata = 32'h1234;
        cycle();
        idle();
        chk_eq("sb_clr",  {62'd0, rbusy}, 64'd0);
        chk_eq("sb_data", rdata, {32'h1234, 32'h1234});
        regwrite = 1'b1; waddr = 5'd5; wdata = 32'h1234;
        rsv_en = 1'b1; rsv_addr = 5'd5;
        cycle();
        idle();
        chk_eq("sb_both_busy", {62'd0, rbusy}, 64'd3);
        chk_eq("sb_both_data", {32'd0, rdata[31:0]}, 64'h1234);
        cycle();

        // Operations during clear are ignored.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        regwrite = 1'b1; waddr = 5'd3; wdata = 32'hCAFE_F00D;
        rsv_en = 1'b1; rsv_addr = 5'd3;
        set_raddr(3, 3);
        wait_ready("clr_len_ops");
        idle();
        chk_eq("clr_ops_data",  rdata, 64'd0);
        chk_eq("clr_ops_rbusy", {62'd0, rbusy}, 64'd0);
        cycle();

        // Mid-operation reset.
        regwrite = 1'b1; waddr = 5'd7; wdata = 32'hFFFF_FFFF;
        cycle();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        cycle();
        idle();
        set_raddr(7, 9);
        cycle();
        reset = 1'b1;
        #1;
        chk_eq("mid_ready_drop", {63'd0, ready}, 64'd0);
        cycle();
        reset = 1'b0;
        wait_ready("clr_len_mid");
        chk_eq("mid_x7", {32'd0, rdata[31:0]}, 64'd0);
        chk_eq("mid_x9_busy", {63'd0, rbusy[1]}, 64'd0);

        // Randomized traffic, with occasional resets.
        for (int k = 0; k < 600; k++) begin
            int a0, a1;
            regwrite = 1'($urandom_range(0, 1));
            waddr    = AW'($urandom_range(0, NREGS - 1));
            wdata    = $urandom;
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NREGS - 1));
            a0 = ($urandom_range(0, 2) == 0) ? int'(waddr) : int'($urandom_range(0, NREGS - 1));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, NREGS - 1));
            set_raddr(a0, a1);
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the RISC-V core: the successor to the fixed 32x32, two-read/one-write `Register` block. It adds configurable width, depth and read-port count, plus a per-register busy scoreboard for long-latency producers. A post-reset clear sequencer zeroes the array so it can map to reset-less storage. An optional same-cycle write-to-read bypass is compiled in by macro. It sits between decode (read/reserve) and writeback (write).

## Interface
Parameters:
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of registers; power of two, at least 4; `AW = $clog2(NREGS)`.
- `NRD`, 2, number of read ports, 1 to 4.

Ports:
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `reset`, in, 1, asynchronous, active-high.
- `ready`, out, 1: array cleared and block accepting operations.
- `regwrite`, in, 1: write enable.
- `waddr`, in, AW: write address.
- `wdata`, in, XLEN: write data.
- `rsv_en`, in, 1: reserve request; sets the busy bit for `rsv_addr`.
- `rsv_addr`, in, AW: register to mark pending.
- `raddr`, in, NRD*AW: packed read addresses; port i is at `[i*AW +: AW]`.
- `rdata`, out, NRD*XLEN: packed read data.
- `rbusy`, out, NRD: busy bit of each read address.

## Operation
- Register 0 is hardwired to zero:
  - writes and reserves to address 0 are ignored;
  - reads of address 0 return 0 with `rbusy` = 0.
- Reads are combinational from the array and the busy vector.
- Write: when `regwrite` and `ready` are high and `waddr` is not 0:
  - `wdata` is stored at the edge;
  - `busy[waddr]` is cleared at the edge.
- Reserve: when `rsv_en` and `ready` are high and `rsv_addr` is not 0, `busy[rsv_addr]` is set at the edge.
- Write and reserve to the same address in the same cycle:
  - data is stored;
  - busy ends at 1, because the reserve belongs to a new producer.
- Write to a register that is not busy is legal; busy stays 0.
- Clear FSM, states CLEAR and RUN:
  - `reset` forces CLEAR, sets index counter `idx` to 1 and clears all busy bits.
  - In CLEAR, entry `idx` is written with 0 each cycle, then `idx` increments.
  - When `idx` = NREGS-1 has been written, the FSM moves to RUN.
  - RUN is held until the next reset.
- While in CLEAR:
  - `ready` = 0;
  - `regwrite` and `rsv_en` are ignored;
  - all `rdata` = 0 and all `rbusy` = 0.
- Reset asserted mid-operation (either state) restarts the clear sequence; prior contents are lost.

## Timing
- Reset values:
  - `ready` = 0, `rdata` = 0, `rbusy` = 0;
  - FSM = CLEAR, `idx` = 1, busy vector = 0.
- Clear duration: after `reset` deasserts, exactly NREGS-1 rising edges, then `ready` = 1. For NREGS = 32 that is 31 cycles.
- Write-to-read latency without bypass: data and busy clear are visible on `rdata`/`rbusy` from the cycle after the write edge.
- Reserve-to-`rbusy` latency: 1 cycle, not bypassed.
- Multiple read ports on the same address return identical data.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - when `regwrite` and `ready` are high and `waddr` equals `raddr[i]` (not 0), `rdata[i]` = `wdata` combinationally;
  - `rbusy[i]` = 0 in that cycle, unless a same-cycle reserve to that address is in progress (reserve is not bypassed, so the registered busy bit applies).
- Undefined: reads always come from the stored array; write-to-read latency is 1 cycle.

## Structure
- Shared package `regfile_pkg`:
  - FSM state enum (`RF_CLEAR`, `RF_RUN`);
  - default `XLEN`/`NREGS` constants;
  - the `REG_ZERO` address constant.
- One sub-module, `regfile_scoreboard`: busy vector with set/clear/reset logic and the NRD busy lookups.
- Array, clear FSM, read muxes and bypass live in the top module.

## Test plan
- Reset clear:
  - stimulus: pulse `reset` for 2 cycles, then release;
  - response: `ready` rises after exactly 31 edges; then every register reads 0 with `rbusy` = 0.
- Basic write/read:
  - stimulus: write 32'hAAAA_AAAA to x1, then 32'h5555_5555 to x2; read port 0 = x2, port 1 = x1;
  - response: 32'h5555_5555 and 32'hAAAA_AAAA the cycle after each write; same-cycle read returns the new value only with `REGFILE_BYPASS_EN`.
- x0 protection:
  - stimulus: write 32'hDEAD_BEEF to x0 and reserve x0;
  - response: reads of x0 = 0 and `rbusy` = 0.
- Scoreboard:
  - stimulus: reserve x5; next cycle `rbusy` = 1; write 32'h1234 to x5;
  - response: `rbusy` = 0 next cycle. A simultaneous write and reserve to x5 leaves `rbusy` = 1 with data 32'h1234.
- Ops during clear:
  - stimulus: assert `regwrite` and `rsv_en` to x3 while `ready` = 0;
  - response: after `ready`, x3 reads 0 and is not busy.
- Mid-operation reset:
  - stimulus: write 32'hFFFF_FFFF to x7, reserve x9, then assert `reset` for 1 cycle;
  - response: `ready` drops immediately; after the clear, x7 = 0 and x9 is not busy.
